uart_tx_fifo_ctrl: RTL and testbench

//  Upstream feeder for the UART transmitter. Buffers host bytes in a synchronous FIFO.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tx_fifo_ctrl_if.sv | 21 ++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_tx_fifo_ctrl.sv | 58 +++++
 tb/tb_uart_tx_fifo_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths and the tx feeder state encoding
package uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// uart_tx_fifo_ctrl_if: host/transmitter side signals of the tx FIFO controller
interface uart_tx_fifo_ctrl_if import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  flush;
  logic                  tx_busy;
  logic                  tx_en;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  modport master (output wr_en, wr_data, flush, tx_busy,
                  input  tx_en, tx_data, full, empty, count, overflow);
  modport slave  (input  wr_en, wr_data, flush, tx_busy,
                  output tx_en, tx_data, full, empty, count, overflow);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with occupancy count, sticky overflow and flush
module uart_sync_fifo import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CNT_W     = AW + 1
) (
  input  logic                  tx_clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_ok, rd_ok;
  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign wr_ok   = push && !full;
  assign rd_ok   = pop && !empty;
  assign rd_data = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge tx_clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(wr_ok);
      rd_ptr   <= rd_ptr + AW'(rd_ok);
      count    <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      overflow <= overflow | (push && full);
    end
  always_ff @(posedge tx_clk)
    if (wr_ok && !flush) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: buffers host bytes and launches them one at a time into the UART transmitter
module uart_tx_fifo_ctrl import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input logic               tx_clk,
  input logic               rst,
  uart_tx_fifo_ctrl_if.slave bus
);
  ctrl_state_t           state_q, state_d;
  logic                  tx_en_q, tx_en_d, pop;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d, rd_data;
  uart_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .tx_clk   (tx_clk),
    .rst      (rst),
    .push     (bus.wr_en),
    .wr_data  (bus.wr_data),
    .pop      (pop),
    .flush    (bus.flush),
    .rd_data  (rd_data),
    .full     (bus.full),
    .empty    (bus.empty),
    .count    (bus.count),
    .overflow (bus.overflow)
  );
  always_ff @(posedge tx_clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  // a launch coinciding with flush still happens; the fifo ignores the pop
  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE:
        if (!bus.empty && !bus.tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = rd_data;
          pop       = 1'b1;
          state_d   = LAUNCH;
        end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: scoreboard bench with a simple busy model standing in for the transmitter
module tb_uart_tx_fifo_ctrl;
  logic       tx_clk = 1'b0;
  logic       rst    = 1'b0;
  int         n_checks = 0, n_fail = 0, launches = 0, max_count = 0;
  int         busy_len = 10, bcnt = 0;
  logic       busy_hold = 1'b0, prev_en = 1'b0;
  logic [7:0] sb [$];

  uart_tx_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();
  uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(16)) dut (.tx_clk(tx_clk), .rst(rst), .bus(bus));

  always #5 tx_clk = ~tx_clk;

  // transmitter stand-in: busy rises the cycle after it samples tx_en, lasts busy_len cycles
  always @(posedge tx_clk or negedge rst)
    if (!rst) bcnt <= 0;
    else if (bus.tx_en) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  assign bus.tx_busy = busy_hold | (bcnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge tx_clk) begin
    if (!rst) prev_en = 1'b0;
    else begin
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
      if (bus.tx_en) begin
        launches++;
        check("tx_en_width", {31'd0, prev_en}, 0);
        check("busy_at_launch", {31'd0, bus.tx_busy}, 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_launch: tx_data=%0h with no byte expected", bus.tx_data);
        end else check("tx_data_order", bus.tx_data, sb.pop_front());
      end
      prev_en = bus.tx_en;
    end
  end

  task automatic wr(input logic [7:0] d, input bit exp);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (exp) sb.push_back(d);
    @(negedge tx_clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bcnt != 0 || bus.tx_en || !bus.empty) && n < 3000) begin
      @(negedge tx_clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: drain timeout, %0d bytes outstanding, need 0", name, sb.size());
    end
    repeat (3) @(negedge tx_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.flush = 1'b0;
    repeat (3) @(negedge tx_clk);
    rst = 1'b1;
    @(negedge tx_clk);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_tx_en", bus.tx_en, 0);
    check("rst_tx_data", bus.tx_data, 0);
    // single byte latency
    wr(8'hA5, 1);
    check("t1_count_after_write", bus.count, 1);
    check("t1_tx_en_e1", bus.tx_en, 0);
    @(negedge tx_clk);
    check("t1_tx_en_e2", bus.tx_en, 1);
    check("t1_tx_data", bus.tx_data, 8'hA5);
    check("t1_count_after_pop", bus.count, 0);
    @(negedge tx_clk);
    check("t1_tx_en_low", bus.tx_en, 0);
    check("t1_tx_data_hold", bus.tx_data, 8'hA5);
    drain("t1");
    // back-to-back writes
    wr(8'h11, 1);
    wr(8'h22, 1);
    wr(8'h33, 1);
    drain("t2");
    check("t2_launches", launches, 4);
    // fill past full while transmitter busy
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1);
    check("t3_full", bus.full, 1);
    check("t3_count16", bus.count, 16);
    check("t3_no_overflow_yet", bus.overflow, 0);
    wr(8'h50, 0);
    check("t3_overflow", bus.overflow, 1);
    check("t3_count_stays16", bus.count, 16);
    busy_hold = 1'b0;
    drain("t3");
    check("t3_launches", launches, 20);
    check("t3_overflow_sticky", bus.overflow, 1);
    check("t3_empty", bus.empty, 1);
    // flush while a frame is in flight
    busy_len = 40;
    for (int i = 0; i < 17; i++) wr(8'h80 + 8'(i), i == 0);
    check("t4_count16", bus.count, 16);
    check("t4_full", bus.full, 1);
    bus.flush = 1'b1;
    @(negedge tx_clk);
    bus.flush = 1'b0;
    check("t4_flush_count", bus.count, 0);
    check("t4_flush_empty", bus.empty, 1);
    check("t4_flush_overflow", bus.overflow, 0);
    check("t4_flush_full", bus.full, 0);
    check("t4_inflight_busy", bus.tx_busy, 1);
    drain("t4");
    check("t4_launches", launches, 21);
    // pointer wrap with flow control on full
    busy_len = 1;
    max_count = 0;
    for (int i = 0; i < 40; i++) begin
      while (bus.full) @(negedge tx_clk);
      wr(8'(i), 1);
    end
    drain("t5");
    check("t5_launches", launches, 61);
    check("t5_max_count_le_depth", {31'd0, max_count <= 16}, 1);
    check("t5_overflow_clear", bus.overflow, 0);
    // async reset during WAIT_DONE
    busy_len = 40;
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i), i == 0);
    repeat (3) @(negedge tx_clk);
    check("t6_count5", bus.count, 5);
    check("t6_busy", bus.tx_busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_tx_en", bus.tx_en, 0);
    check("t6_rst_tx_data", bus.tx_data, 0);
    check("t6_rst_empty", bus.empty, 1);
    check("t6_rst_count", bus.count, 0);
    @(negedge tx_clk);
    rst = 1'b1;
    repeat (20) @(negedge tx_clk);
    check("t6_empty_after", bus.empty, 1);
    check("t6_no_launch", launches, 62);
    busy_len = 10;
    wr(8'h5A, 1);
    drain("t6");
    check("t6_launches", launches, 63);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
